mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes BusA/BusB (rs/rt operands) and computes MULT/MULTU/DIV/DIVU into HI/LO registers at one bit per cycle.
- Hi/Lo outputs feed the MFHI/MFLO writeback path onto BusW; Busy stalls the pipeline controller.
- Also supports direct MTHI/MTLO writes.

Parameters:
W, 32, operand width; Hi and Lo are each W bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > W.

Ports:
Clk  input  1  rising-edge clock; the design's only clock
Rst_n  input  1  asynchronous, active-low reset
Start  input  1  begin the operation selected by Op; sampled only in IDLE
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
BusA  input  W  operand A (multiplicand or dividend), captured on the accepted Start edge
BusB  input  W  operand B (multiplier or divisor), captured on the accepted Start edge
HiWr  input  1  MTHI: write HiLoIn to Hi
LoWr  input  1  MTLO: write HiLoIn to Lo
HiLoIn  input  W  data for MTHI/MTLO
Busy  output  1  operation in progress; Start, HiWr and LoWr are ignored while high
Done  output  1  one-cycle pulse; Hi/Lo hold the new result in this cycle
DivByZero  output  1  one-cycle pulse, coincident with Done, for DIV/DIVU with BusB==0
Hi  output  W  HI register
Lo  output  W  LO register

Behaviour:
- Reset (async, Rst_n=0): Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state=IDLE, counter=0. Reset mid-operation abandons it; Hi/Lo read 0.
- States are IDLE, RUN and FIX.

IDLE:
- On an edge with Start=1: latch Op; latch |BusA| and |BusB| for signed ops, raw values for unsigned ops.
- On the same edge, latch the sign flags: product sign = A[W-1]^B[W-1]; remainder sign = A[W-1].
- On the same edge: counter=0, Busy=1, state goes to RUN. The exception is DIV/DIVU with BusB==0, which goes straight to FIX with the dbz flag set.
- Start=1 takes priority over HiWr/LoWr in the same cycle; the writes are dropped.
- With Start=0: HiWr writes Hi and LoWr writes Lo. Both may be asserted in one cycle.

RUN (exactly W cycles; counter increments each cycle and the state exits when counter==W-1):
- Multiply: shift-add. A 2W-bit accumulator examines the multiplier LSB, adds the multiplicand into the upper half when the bit is 1, then shifts right 1 (W+1-bit sum, carry kept).
- Divide: restoring division, MSB first. {rem, quo} shifts left 1; if rem >= divisor then rem -= divisor and quo LSB = 1.

FIX (1 cycle):
- Signed multiply with negative product sign: {Hi,Lo} = two's-complement negation of the 2W-bit product.
- Signed divide: Lo = quotient, negated if the product sign is 1; Hi = remainder, negated if the remainder sign is 1.
- Divide by zero: Lo = all-ones; Hi = BusA exactly as it was at Start. Hi is not made absolute or sign-fixed in this case.
- Exit on the same edge: Busy=0, Done=1 and DivByZero=dbz for the next cycle, state goes to IDLE.

Timing:
- Accepted Start at edge N: Busy=1 from after edge N.
- Normal operation: Hi/Lo update and Done=1 after edge N+W+1 (edge N+33 for W=32); Busy is low in the Done cycle.
- Divide by zero: Done after edge N+2.
- Back-to-back: a Start presented in the Done cycle is accepted.

Overflow:
- DIV 0x80000000 / 0xFFFFFFFF wraps naturally to Lo=0x80000000, Hi=0, with no flag.

Decomposition:
- mdu_pkg holds the Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state encoding (S_IDLE, S_RUN, S_FIX) and default W.
- One combinational sub-module, mdu_step, performs a single shift-add or restore-subtract iteration selected by an is_div input.
- The FSM, counter, sign fixup and Hi/Lo registers live in mult_div_unit.

Test Plan:
1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Done pulses exactly 33 edges after the Start edge; Busy is high for 33 cycles.
2. MULT 0xFFFFFFFD (-3) * 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then DIVU 100/7 -> Lo=14, Hi=2.
3. DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
4. DIVU 0x1234/0 -> Done and DivByZero high together after edge N+2, Lo=0xFFFFFFFF, Hi=0x1234. A following MULTU 2*3 shows DivByZero=0 on its Done.
5. In IDLE: HiWr=1, LoWr=1, HiLoIn=0xA5A5A5A5 -> Hi=Lo=0xA5A5A5A5. During RUN: HiWr pulse and a second Start -> both ignored and the first result is correct. Start+HiWr in the same IDLE cycle -> Hi comes from the operation only.
6. Rst_n low at cycle 10 of a DIV -> Busy, Done, Hi and Lo go to 0 immediately (asynchronously). After release, a fresh MULTU 5*5 gives Lo=25, Hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and default datapath widths.
package mdu_pkg;

    localparam int MDU_W     = 32;
    localparam int MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of either the shift-add multiplier (accumulator shifts right)
// or the restoring divider (remainder/quotient shift left, MSB first).
module mdu_step #(
    parameter int W = 32
) (
    input  logic         is_div_i,
    input  logic [W-1:0] acc_hi_i,
    input  logic [W-1:0] acc_lo_i,
    input  logic [W-1:0] operand_i,
    output logic [W-1:0] acc_hi_o,
    output logic [W-1:0] acc_lo_o
);

    logic [W:0] sum;
    logic [W:0] remShift;

    // The partial remainder never reaches the divisor, so the W-bit difference is exact.
    always_comb begin
        sum      = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : '0);
        remShift = {acc_hi_i, acc_lo_i[W-1]};
        if (is_div_i) begin
            if (remShift >= {1'b0, operand_i}) begin
                acc_hi_o = remShift[W-1:0] - operand_i;
                acc_lo_o = {acc_lo_i[W-2:0], 1'b1};
            end else begin
                acc_hi_o = remShift[W-1:0];
                acc_lo_o = {acc_lo_i[W-2:0], 1'b0};
            end
        end else begin
            acc_hi_o = sum[W:1];
            acc_lo_o = {sum[0], acc_lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO one bit per cycle,
// with MTHI/MTLO writes accepted while idle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int W     = MDU_W,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Start,
    input  logic [1:0]   Op,
    input  logic [W-1:0] BusA,
    input  logic [W-1:0] BusB,
    input  logic         HiWr,
    input  logic         LoWr,
    input  logic [W-1:0] HiLoIn,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero,
    output logic [W-1:0] Hi,
    output logic [W-1:0] Lo
);

    mdu_state_e     state_q;
    mdu_op_e        op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]   accHi_q, accLo_q, operand_q, rawA_q;
    logic [W-1:0]   accHi_d, accLo_d;
    logic [W-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic           prodNeg_q, remNeg_q, dbz_q;
    logic           busy_q, done_q, dbzOut_q;

    logic           startSigned;
    logic [W-1:0]   absA, absB;
    logic [2*W-1:0] prod, prodNegated;

    assign startSigned = ~Op[0];
    assign absA = (startSigned && BusA[W-1]) ? -BusA : BusA;
    assign absB = (startSigned && BusB[W-1]) ? -BusB : BusB;

    mdu_step #(.W(W)) u_step (
        .is_div_i  (op_q[1]),
        .acc_hi_i  (accHi_q),
        .acc_lo_i  (accLo_q),
        .operand_i (operand_q),
        .acc_hi_o  (accHi_d),
        .acc_lo_o  (accLo_d)
    );

    // Sign correction of the unsigned magnitude result; divide-by-zero hands back the raw dividend.
    always_comb begin
        prod        = {accHi_q, accLo_q};
        prodNegated = -prod;
        hi_d        = accHi_q;
        lo_d        = accLo_q;
        if (dbz_q) begin
            hi_d = rawA_q;
            lo_d = '1;
        end else if (op_q == OP_MULT && prodNeg_q) begin
            {hi_d, lo_d} = prodNegated;
        end else if (op_q == OP_DIV) begin
            if (prodNeg_q) lo_d = -accLo_q;
            if (remNeg_q)  hi_d = -accHi_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            operand_q <= '0;
            rawA_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            prodNeg_q <= 1'b0;
            remNeg_q  <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbzOut_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            dbzOut_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        op_q      <= mdu_op_e'(Op);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        rawA_q    <= BusA;
                        prodNeg_q <= BusA[W-1] ^ BusB[W-1];
                        remNeg_q  <= BusA[W-1];
                        accHi_q   <= '0;
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                        accLo_q   <= Op[1] ? absA : absB;
                        operand_q <= Op[1] ? absB : absA;
                        if (Op[1] && BusB == '0) begin
                            state_q <= S_FIX;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            dbz_q   <= 1'b0;
                        end
                    end else begin
                        if (HiWr) hi_q <= HiLoIn;
                        if (LoWr) lo_q <= HiLoIn;
                    end
                end
                S_RUN: begin
                    accHi_q <= accHi_d;
                    accLo_q <= accLo_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    // Divide-by-zero enters FIX with the counter at zero and lingers one extra cycle.
                    if (dbz_q && cnt_q == '0) begin
                        cnt_q <= CNT_W'(1);
                    end else begin
                        hi_q     <= hi_d;
                        lo_q     <= lo_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        dbzOut_q <= dbz_q;
                        dbz_q    <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbzOut_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] BusA = '0;
    logic [31:0] BusB = '0;
    logic        HiWr = 1'b0;
    logic        LoWr = 1'b0;
    logic [31:0] HiLoIn = '0;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int failures = 0;

    mult_div_unit #(.W(32), .CNT_W(6)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB),
        .HiWr(HiWr), .LoWr(LoWr), .HiLoIn(HiLoIn),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    // Expected HI/LO from ordinary integer arithmetic on the architectural operands.
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dbz = 1'b0;
        hi = '0;
        lo = '0;
        if (op == 2'b00) begin
            p = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == 2'b01) begin
            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dbz = 1'b1;
            hi = a;
            lo = '1;
        end else if (op == 2'b11) begin
            lo = a / b;
            hi = a % b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    // Present Start for exactly one rising edge; also retires any pending MTHI/MTLO strobes.
    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op;
        BusA = a;
        BusB = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        HiWr = 1'b0;
        LoWr = 1'b0;
    endtask

    // Count edges until Done (bounded); busyCnt includes the cycle right after the Start edge.
    task automatic waitDone(output int lat, output int busyCnt, output logic tout);
        lat = 0;
        busyCnt = Busy ? 1 : 0;
        tout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk);
            #1;
            lat++;
            if (Done) begin
                tout = 1'b0;
                break;
            end
            if (Busy) busyCnt++;
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        #3;
        checks++;
        if ({Busy, Done, DivByZero, Hi, Lo} !== 67'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
                     Busy, Done, DivByZero, Hi, Lo);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_multu_max();
        int lat, bc;
        logic tout;
        startOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(lat, bc, tout);
        checks++;
        if (tout) begin failures++; $display("[TB] FAIL multu_max_timeout: Done never seen"); end
        checks++;
        if (lat != 33) begin failures++; $display("[TB] FAIL multu_latency: got %0d edges, want 33", lat); end
        checks++;
        if (bc != 33) begin failures++; $display("[TB] FAIL multu_busy_cycles: got %0d, want 33", bc); end
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_in_done: got %b, want 0", Busy); end
        checks++;
        if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
            failures++;
            $display("[TB] FAIL multu_max_result: got hi=%h lo=%h, want hi=fffffffe lo=00000001", Hi, Lo);
        end
        checks++;
        if (DivByZero !== 1'b0) begin failures++; $display("[TB] FAIL multu_dbz: got %b, want 0", DivByZero); end
        @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b0) begin failures++; $display("[TB] FAIL done_one_cycle: got %b, want 0", Done); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic tout;
        startOp(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFEB) begin
            failures++;
            $display("[TB] FAIL mult_neg: got hi=%h lo=%h tout=%b, want hi=ffffffff lo=ffffffeb", Hi, Lo, tout);
        end
        startOp(OP_DIVU, 32'd100, 32'd7);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || lat != 33 || Hi !== 32'd2 || Lo !== 32'd14) begin
            failures++;
            $display("[TB] FAIL divu_b2b: got hi=%0d lo=%0d lat=%0d, want hi=2 lo=14 lat=33", Hi, Lo, lat);
        end
        startOp(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("[TB] FAIL div_neg: got hi=%h lo=%h, want hi=ffffffff lo=fffffffd", Hi, Lo);
        end
        startOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || Hi !== 32'd0 || Lo !== 32'h8000_0000 || DivByZero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL div_overflow: got hi=%h lo=%h dbz=%b, want hi=0 lo=80000000 dbz=0",
                     Hi, Lo, DivByZero);
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        logic tout;
        startOp(OP_DIVU, 32'h0000_1234, 32'd0);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || lat != 2) begin failures++; $display("[TB] FAIL dbz_latency: got %0d, want 2", lat); end
        checks++;
        if (DivByZero !== 1'b1 || Hi !== 32'h0000_1234 || Lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL divu_zero: got dbz=%b hi=%h lo=%h, want dbz=1 hi=00001234 lo=ffffffff",
                     DivByZero, Hi, Lo);
        end
        startOp(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || DivByZero !== 1'b1 || Hi !== 32'hFFFF_FFFB || Lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL div_zero_raw: got dbz=%b hi=%h lo=%h, want dbz=1 hi=fffffffb lo=ffffffff",
                     DivByZero, Hi, Lo);
        end
        startOp(OP_MULTU, 32'd2, 32'd3);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || DivByZero !== 1'b0 || Lo !== 32'd6 || Hi !== 32'd0) begin
            failures++;
            $display("[TB] FAIL after_dbz: got dbz=%b hi=%h lo=%h, want dbz=0 hi=0 lo=6", DivByZero, Hi, Lo);
        end
    endtask

    task automatic test_hilo_writes();
        int lat, bc;
        logic tout;
        logic [31:0] eHi, eLo, prevHi, prevLo;
        logic eDbz;
        HiLoIn = 32'hA5A5_A5A5;
        HiWr = 1'b1;
        LoWr = 1'b1;
        @(posedge Clk);
        #1;
        HiWr = 1'b0;
        LoWr = 1'b0;
        checks++;
        if (Hi !== 32'hA5A5_A5A5 || Lo !== 32'hA5A5_A5A5) begin
            failures++;
            $display("[TB] FAIL mthi_mtlo: got hi=%h lo=%h, want both a5a5a5a5", Hi, Lo);
        end
        refModel(OP_MULTU, 32'd12345, 32'd6789, eHi, eLo, eDbz);
        startOp(OP_MULTU, 32'd12345, 32'd6789);
        repeat (3) @(posedge Clk);
        HiLoIn = 32'h1111_1111;
        HiWr = 1'b1;
        Op = OP_DIVU;
        BusA = 32'd99;
        BusB = 32'd0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        HiWr = 1'b0;
        Start = 1'b0;
        checks++;
        if (Hi !== 32'hA5A5_A5A5 || Busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL write_during_run: got hi=%h busy=%b, want hi=a5a5a5a5 busy=1", Hi, Busy);
        end
        waitDone(lat, bc, tout);
        checks++;
        if (tout || Hi !== eHi || Lo !== eLo || DivByZero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignored_start: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=0",
                     Hi, Lo, DivByZero, eHi, eLo);
        end
        prevHi = Hi;
        prevLo = Lo;
        HiLoIn = 32'h5A5A_5A5A;
        HiWr = 1'b1;
        LoWr = 1'b1;
        startOp(OP_MULTU, 32'd2, 32'd3);
        checks++;
        if (Hi !== prevHi || Lo !== prevLo) begin
            failures++;
            $display("[TB] FAIL start_priority: got hi=%h lo=%h, want hi=%h lo=%h", Hi, Lo, prevHi, prevLo);
        end
        waitDone(lat, bc, tout);
        checks++;
        if (tout || Hi !== 32'd0 || Lo !== 32'd6) begin
            failures++;
            $display("[TB] FAIL start_priority_result: got hi=%h lo=%h, want hi=0 lo=6", Hi, Lo);
        end
    endtask

    task automatic test_reset_midop();
        int lat, bc;
        logic tout;
        startOp(OP_DIV, 32'h7654_3210, 32'd7);
        repeat (9) @(posedge Clk);
        #3;
        checks++;
        if (Busy !== 1'b1 || Lo !== 32'd6) begin
            failures++;
            $display("[TB] FAIL pre_reset_state: got busy=%b lo=%h, want busy=1 lo=6", Busy, Lo);
        end
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, Hi, Lo} !== 66'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b hi=%h lo=%h, want all zero", Busy, Done, Hi, Lo);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        startOp(OP_MULTU, 32'd5, 32'd5);
        waitDone(lat, bc, tout);
        checks++;
        if (tout || lat != 33 || Hi !== 32'd0 || Lo !== 32'd25) begin
            failures++;
            $display("[TB] FAIL post_reset_mult: got hi=%h lo=%h lat=%0d, want hi=0 lo=25 lat=33", Hi, Lo, lat);
        end
    endtask

    task automatic test_random_ops(input int n);
        int lat, bc, eLat;
        logic tout, eDbz;
        logic [1:0] op;
        logic [31:0] a, b, eHi, eLo;
        for (int k = 0; k < n; k++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            refModel(op, a, b, eHi, eLo, eDbz);
            eLat = eDbz ? 2 : 33;
            startOp(op, a, b);
            waitDone(lat, bc, tout);
            checks++;
            if (tout || lat != eLat) begin
                failures++;
                $display("[TB] FAIL rand_latency[%0d]: op=%0d got %0d (tout=%b), want %0d", k, op, lat, tout, eLat);
            end
            checks++;
            if (Hi !== eHi || Lo !== eLo || DivByZero !== eDbz) begin
                failures++;
                $display("[TB] FAIL rand_result[%0d]: op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                         k, op, a, b, Hi, Lo, DivByZero, eHi, eLo, eDbz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_div_by_zero();
        test_hilo_writes();
        test_reset_midop();
        test_random_ops(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
